// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC-SPM control unit: opcodes, controller
// states, bus-2 select codes and small classification helpers.
package risc_spm_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_RD   = 4'h5;
    localparam logic [3:0] OP_WR   = 4'h6;
    localparam logic [3:0] OP_BR   = 4'h7;
    localparam logic [3:0] OP_BRZ  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;
    localparam logic [1:0] SEL2_RSVD = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FET1,
        S_FET2,
        S_DEC,
        S_EX1,
        S_RD1,
        S_RD2,
        S_WR1,
        S_WR2,
        S_BR1,
        S_BR2,
        S_HALT
    } state_t;

    // States that talk to memory and therefore wait on mem_ready
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FET2) || (s == S_RD1) || (s == S_RD2) ||
               (s == S_WR1)  || (s == S_WR2) || (s == S_BR1) || (s == S_BR2);
    endfunction

    // Opcodes 9..E have no meaning and stop the machine with an error
    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'h9) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/risc_spm_ctrl_dec.sv
// Combinational output decoder: turns the current state, IR fields, zero
// flag and memory handshake into datapath strobes and bus selects.
module risc_spm_ctrl_dec
    import risc_spm_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int REG_ADDR_W = 2,
    parameter int NUM_REGS   = 1 << REG_ADDR_W,
    parameter int SEL1_W     = $clog2(NUM_REGS + 1)
) (
    input  state_t                state,
    input  logic [WORD_SIZE-1:0]  instruction,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic [NUM_REGS-1:0]   load_reg,
    output logic                  load_pc,
    output logic                  inc_pc,
    output logic                  load_ir,
    output logic                  load_add_r,
    output logic                  load_reg_y,
    output logic                  load_reg_z,
    output logic [SEL1_W-1:0]     sel_bus_1,
    output logic [1:0]            sel_bus_2,
    output logic                  mem_req,
    output logic                  write,
    output logic                  halted
);

    localparam logic [SEL1_W-1:0] SEL1_PC = SEL1_W'(NUM_REGS);

    logic [3:0]            opcode;
    logic [REG_ADDR_W-1:0] src;
    logic [REG_ADDR_W-1:0] dest;
    logic [NUM_REGS-1:0]   dest_hot;

    assign opcode   = instruction[WORD_SIZE-1 -: 4];
    assign src      = instruction[2*REG_ADDR_W-1:REG_ADDR_W];
    assign dest     = instruction[REG_ADDR_W-1:0];
    assign dest_hot = {{(NUM_REGS-1){1'b0}}, 1'b1} << dest;

    // Per-state outputs; memory states only fire strobes once mem_ready is seen
    always_comb begin
        load_reg   = '0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        sel_bus_1  = '0;
        sel_bus_2  = SEL2_ALU;
        mem_req    = is_mem_state(state);
        write      = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FET1: begin
                sel_bus_1  = SEL1_PC;
                load_add_r = 1'b1;
            end
            S_FET2: begin
                sel_bus_2 = SEL2_MEM;
                load_ir   = mem_ready;
                inc_pc    = mem_ready;
            end
            S_DEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel_bus_1  = SEL1_W'(src);
                        load_reg_y = 1'b1;
                    end
                    OP_NOT: begin
                        sel_bus_1  = SEL1_W'(src);
                        sel_bus_2  = SEL2_ALU;
                        load_reg   = dest_hot;
                        load_reg_z = 1'b1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        sel_bus_1  = SEL1_PC;
                        load_add_r = 1'b1;
                    end
                    OP_BRZ: begin
                        if (zero) begin
                            sel_bus_1  = SEL1_PC;
                            load_add_r = 1'b1;
                        end else begin
                            inc_pc = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            S_EX1: begin
                sel_bus_1  = SEL1_W'(dest);
                sel_bus_2  = SEL2_ALU;
                load_reg   = dest_hot;
                load_reg_z = 1'b1;
            end
            S_RD1, S_WR1: begin
                sel_bus_2  = SEL2_MEM;
                load_add_r = mem_ready;
                inc_pc     = mem_ready;
            end
            S_RD2: begin
                sel_bus_2 = SEL2_MEM;
                load_reg  = mem_ready ? dest_hot : '0;
            end
            S_WR2: begin
                sel_bus_1 = SEL1_W'(src);
                write     = mem_ready;
            end
            S_BR1: begin
                sel_bus_2  = SEL2_MEM;
                load_add_r = mem_ready;
            end
            S_BR2: begin
                sel_bus_2 = SEL2_MEM;
                load_pc   = mem_ready;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/risc_spm_ctrl.sv
// RISC-SPM control unit: state register, sticky error flag and next-state
// sequencing; output decoding lives in risc_spm_ctrl_dec.
module risc_spm_ctrl
    import risc_spm_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int REG_ADDR_W = 2,
    parameter int NUM_REGS   = 1 << REG_ADDR_W,
    parameter int SEL1_W     = $clog2(NUM_REGS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_SIZE-1:0]  instruction,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic [NUM_REGS-1:0]   load_reg,
    output logic                  load_pc,
    output logic                  inc_pc,
    output logic                  load_ir,
    output logic                  load_add_r,
    output logic                  load_reg_y,
    output logic                  load_reg_z,
    output logic [SEL1_W-1:0]     sel_bus_1,
    output logic [1:0]            sel_bus_2,
    output logic                  mem_req,
    output logic                  write,
    output logic                  halted,
    output logic                  err
);

    state_t     state;
    state_t     state_next;
    logic       err_next;
    logic [3:0] opcode;

    assign opcode = instruction[WORD_SIZE-1 -: 4];

    // State and error flag; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            err   <= err_next;
        end
    end

    // Sequencing: memory states advance only on mem_ready, HALT is terminal
    always_comb begin
        state_next = state;
        err_next   = err;
        case (state)
            S_IDLE: state_next = S_FET1;
            S_FET1: state_next = S_FET2;
            S_FET2: if (mem_ready) state_next = S_DEC;
            S_DEC: begin
                case (opcode)
                    OP_NOP:                 state_next = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: state_next = S_EX1;
                    OP_NOT:                 state_next = S_FET1;
                    OP_RD:                  state_next = S_RD1;
                    OP_WR:                  state_next = S_WR1;
                    OP_BR:                  state_next = S_BR1;
                    OP_BRZ:                 state_next = zero ? S_BR1 : S_FET1;
                    OP_HALT:                state_next = S_HALT;
                    default: begin
                        state_next = S_HALT;
                        err_next   = is_illegal(opcode);
                    end
                endcase
            end
            S_EX1:  state_next = S_FET1;
            S_RD1:  if (mem_ready) state_next = S_RD2;
            S_RD2:  if (mem_ready) state_next = S_FET1;
            S_WR1:  if (mem_ready) state_next = S_WR2;
            S_WR2:  if (mem_ready) state_next = S_FET1;
            S_BR1:  if (mem_ready) state_next = S_BR2;
            S_BR2:  if (mem_ready) state_next = S_FET1;
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    risc_spm_ctrl_dec #(
        .WORD_SIZE  (WORD_SIZE),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS),
        .SEL1_W     (SEL1_W)
    ) u_dec (
        .state       (state),
        .instruction (instruction),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .load_reg    (load_reg),
        .load_pc     (load_pc),
        .inc_pc      (inc_pc),
        .load_ir     (load_ir),
        .load_add_r  (load_add_r),
        .load_reg_y  (load_reg_y),
        .load_reg_z  (load_reg_z),
        .sel_bus_1   (sel_bus_1),
        .sel_bus_2   (sel_bus_2),
        .mem_req     (mem_req),
        .write       (write),
        .halted      (halted)
    );

endmodule

// File: tb/tb_risc_spm_ctrl.sv
// Scoreboard bench for risc_spm_ctrl: the stimulus process queues the
// expected output vector for each cycle and a monitor compares on the
// falling edge. One instance uses the default sizing, a second uses
// WORD_SIZE=10 / REG_ADDR_W=3.
module tb_risc_spm_ctrl;

    localparam logic [5:0] T_PC  = 6'b100000;
    localparam logic [5:0] T_INC = 6'b010000;
    localparam logic [5:0] T_IR  = 6'b001000;
    localparam logic [5:0] T_ADR = 6'b000100;
    localparam logic [5:0] T_Y   = 6'b000010;
    localparam logic [5:0] T_Z   = 6'b000001;
    localparam logic [3:0] M_REQ = 4'b1000;
    localparam logic [3:0] M_WR  = 4'b0100;
    localparam logic [3:0] M_HLT = 4'b0010;
    localparam logic [3:0] M_ERR = 4'b0001;

    logic clk = 1'b0;

    logic       rst0, zero0, mr0;
    logic [7:0] ir0;
    logic [3:0] load_reg0;
    logic [2:0] sel_bus_1_0;
    logic [1:0] sel_bus_2_0;
    logic load_pc0, inc_pc0, load_ir0, load_add_r0, load_reg_y0, load_reg_z0;
    logic mem_req0, write0, halted0, err0;

    logic       rst1, zero1, mr1;
    logic [9:0] ir1;
    logic [7:0] load_reg1;
    logic [3:0] sel_bus_1_1;
    logic [1:0] sel_bus_2_1;
    logic load_pc1, inc_pc1, load_ir1, load_add_r1, load_reg_y1, load_reg_z1;
    logic mem_req1, write1, halted1, err1;

    logic [31:0] exp_q[$];
    bit          who_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    risc_spm_ctrl #(.WORD_SIZE(8), .REG_ADDR_W(2)) dut0 (
        .clk(clk), .rst(rst0), .instruction(ir0), .zero(zero0), .mem_ready(mr0),
        .load_reg(load_reg0), .load_pc(load_pc0), .inc_pc(inc_pc0), .load_ir(load_ir0),
        .load_add_r(load_add_r0), .load_reg_y(load_reg_y0), .load_reg_z(load_reg_z0),
        .sel_bus_1(sel_bus_1_0), .sel_bus_2(sel_bus_2_0), .mem_req(mem_req0),
        .write(write0), .halted(halted0), .err(err0)
    );

    risc_spm_ctrl #(.WORD_SIZE(10), .REG_ADDR_W(3)) dut1 (
        .clk(clk), .rst(rst1), .instruction(ir1), .zero(zero1), .mem_ready(mr1),
        .load_reg(load_reg1), .load_pc(load_pc1), .inc_pc(inc_pc1), .load_ir(load_ir1),
        .load_add_r(load_add_r1), .load_reg_y(load_reg_y1), .load_reg_z(load_reg_z1),
        .sel_bus_1(sel_bus_1_1), .sel_bus_2(sel_bus_2_1), .mem_req(mem_req1),
        .write(write1), .halted(halted1), .err(err1)
    );

    // Expected-vector layout: load_reg | sel_bus_1 | sel_bus_2 | strobes | misc | pad
    function automatic logic [31:0] mk(input logic [7:0] lr, input logic [3:0] s1,
                                       input logic [1:0] s2, input logic [5:0] strb,
                                       input logic [3:0] misc);
        return {lr, s1, s2, strb, misc, 8'h00};
    endfunction

    function automatic logic [31:0] obs0();
        return {4'b0, load_reg0, 1'b0, sel_bus_1_0, sel_bus_2_0,
                load_pc0, inc_pc0, load_ir0, load_add_r0, load_reg_y0, load_reg_z0,
                mem_req0, write0, halted0, err0, 8'h00};
    endfunction

    function automatic logic [31:0] obs1();
        return {load_reg1, sel_bus_1_1, sel_bus_2_1,
                load_pc1, inc_pc1, load_ir1, load_add_r1, load_reg_y1, load_reg_z1,
                mem_req1, write1, halted1, err1, 8'h00};
    endfunction

    task automatic checkOutput(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the expectation
    task automatic applyStimulus(input bit which, input logic r, input logic [9:0] ir,
                                 input logic z, input logic mr, input logic [31:0] e,
                                 input string n);
        @(posedge clk);
        #1;
        if (!which) begin
            rst0 = r; ir0 = ir[7:0]; zero0 = z; mr0 = mr;
        end else begin
            rst1 = r; ir1 = ir; zero1 = z; mr1 = mr;
        end
        exp_q.push_back(e);
        who_q.push_back(which);
        name_q.push_back(n);
    endtask

    // Pull reset low partway through a cycle; outputs must clear before the next edge
    task automatic midReset(input string n);
        @(posedge clk);
        #2;
        rst0 = 1'b0;
        exp_q.push_back(32'h0);
        who_q.push_back(1'b0);
        name_q.push_back(n);
    endtask

    // Monitor: compare whatever the DUT shows against the oldest queued expectation
    initial begin
        logic [31:0] e;
        bit          w;
        string       n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                w = who_q.pop_front();
                n = name_q.pop_front();
                checkOutput(n, w ? obs1() : obs0(), e);
            end
        end
    end

    initial begin
        rst0 = 1'b0; ir0 = 8'h00; zero0 = 1'b0; mr0 = 1'b1;
        rst1 = 1'b0; ir1 = 10'h000; zero1 = 1'b0; mr1 = 1'b1;
        @(posedge clk);
        applyStimulus(0, 0, 10'h01B, 0, 1, 32'h0, "reset0");
        applyStimulus(1, 0, 10'h07D, 0, 1, 32'h0, "reset1");

        // ADD R2 -> R3
        applyStimulus(0, 1, 10'h01B, 0, 1, 32'h0, "add_idle");
        applyStimulus(0, 1, 10'h01B, 0, 1, mk(0, 4, 0, T_ADR, 0), "add_fet1");
        applyStimulus(0, 1, 10'h01B, 0, 1, mk(0, 0, 2, T_INC | T_IR, M_REQ), "add_fet2");
        applyStimulus(0, 1, 10'h01B, 0, 1, mk(0, 2, 0, T_Y, 0), "add_dec");
        applyStimulus(0, 1, 10'h01B, 0, 1, mk(8'b1000, 3, 0, T_Z, 0), "add_ex1");

        // RD into R1 with three stall cycles in RD2
        applyStimulus(0, 1, 10'h051, 0, 1, mk(0, 4, 0, T_ADR, 0), "rd_fet1");
        applyStimulus(0, 1, 10'h051, 0, 1, mk(0, 0, 2, T_INC | T_IR, M_REQ), "rd_fet2");
        applyStimulus(0, 1, 10'h051, 0, 1, mk(0, 4, 0, T_ADR, 0), "rd_dec");
        applyStimulus(0, 1, 10'h051, 0, 1, mk(0, 0, 2, T_ADR | T_INC, M_REQ), "rd_rd1");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 10'h051, 0, 0, mk(0, 0, 2, 0, M_REQ), "rd_stall");
        applyStimulus(0, 1, 10'h051, 0, 1, mk(8'b0010, 0, 2, 0, M_REQ), "rd_rd2");

        // BRZ not taken, then taken
        applyStimulus(0, 1, 10'h080, 0, 1, mk(0, 4, 0, T_ADR, 0), "brz0_fet1");
        applyStimulus(0, 1, 10'h080, 0, 1, mk(0, 0, 2, T_INC | T_IR, M_REQ), "brz0_fet2");
        applyStimulus(0, 1, 10'h080, 0, 1, mk(0, 0, 0, T_INC, 0), "brz0_dec");
        applyStimulus(0, 1, 10'h080, 1, 1, mk(0, 4, 0, T_ADR, 0), "brz1_fet1");
        applyStimulus(0, 1, 10'h080, 1, 1, mk(0, 0, 2, T_INC | T_IR, M_REQ), "brz1_fet2");
        applyStimulus(0, 1, 10'h080, 1, 1, mk(0, 4, 0, T_ADR, 0), "brz1_dec");
        applyStimulus(0, 1, 10'h080, 0, 1, mk(0, 0, 2, T_ADR, M_REQ), "brz1_br1");
        applyStimulus(0, 1, 10'h080, 0, 1, mk(0, 0, 2, T_PC, M_REQ), "brz1_br2");

        // NOT R2 -> R1, then NOP
        applyStimulus(0, 1, 10'h049, 0, 1, mk(0, 4, 0, T_ADR, 0), "not_fet1");
        applyStimulus(0, 1, 10'h049, 0, 1, mk(0, 0, 2, T_INC | T_IR, M_REQ), "not_fet2");
        applyStimulus(0, 1, 10'h049, 0, 1, mk(8'b0010, 2, 0, T_Z, 0), "not_dec");
        applyStimulus(0, 1, 10'h000, 0, 1, mk(0, 4, 0, T_ADR, 0), "nop_fet1");
        applyStimulus(0, 1, 10'h000, 0, 1, mk(0, 0, 2, T_INC | T_IR, M_REQ), "nop_fet2");
        applyStimulus(0, 1, 10'h000, 0, 1, 32'h0, "nop_dec");

        // WR from R1 with a stall in WR2, completing
        applyStimulus(0, 1, 10'h064, 0, 1, mk(0, 4, 0, T_ADR, 0), "wr_fet1");
        applyStimulus(0, 1, 10'h064, 0, 0, mk(0, 0, 2, 0, M_REQ), "wr_fet2_stall");
        applyStimulus(0, 1, 10'h064, 0, 1, mk(0, 0, 2, T_INC | T_IR, M_REQ), "wr_fet2");
        applyStimulus(0, 1, 10'h064, 0, 1, mk(0, 4, 0, T_ADR, 0), "wr_dec");
        applyStimulus(0, 1, 10'h064, 0, 1, mk(0, 0, 2, T_ADR | T_INC, M_REQ), "wr_wr1");
        applyStimulus(0, 1, 10'h064, 0, 0, mk(0, 1, 0, 0, M_REQ), "wr_wr2_stall");
        applyStimulus(0, 1, 10'h064, 0, 1, mk(0, 1, 0, 0, M_REQ | M_WR), "wr_wr2");

        // Second WR aborted by reset while stalled in WR2
        applyStimulus(0, 1, 10'h064, 0, 1, mk(0, 4, 0, T_ADR, 0), "wra_fet1");
        applyStimulus(0, 1, 10'h064, 0, 1, mk(0, 0, 2, T_INC | T_IR, M_REQ), "wra_fet2");
        applyStimulus(0, 1, 10'h064, 0, 1, mk(0, 4, 0, T_ADR, 0), "wra_dec");
        applyStimulus(0, 1, 10'h064, 0, 1, mk(0, 0, 2, T_ADR | T_INC, M_REQ), "wra_wr1");
        applyStimulus(0, 1, 10'h064, 0, 0, mk(0, 1, 0, 0, M_REQ), "wra_wr2_stall");
        midReset("wra_async_rst");
        applyStimulus(0, 0, 10'h064, 0, 1, 32'h0, "wra_rst_hold");
        applyStimulus(0, 1, 10'h064, 0, 1, 32'h0, "wra_idle");
        applyStimulus(0, 1, 10'h0F0, 0, 1, mk(0, 4, 0, T_ADR, 0), "wra_restart");

        // HALT: stays halted without error for 100 cycles
        applyStimulus(0, 1, 10'h0F0, 0, 1, mk(0, 0, 2, T_INC | T_IR, M_REQ), "halt_fet2");
        applyStimulus(0, 1, 10'h0F0, 0, 1, 32'h0, "halt_dec");
        for (int i = 0; i < 100; i++)
            applyStimulus(0, 1, 10'h0F0, i[0], i[1], mk(0, 0, 0, 0, M_HLT), "halt_hold");
        midReset("halt_async_rst");

        // Illegal opcode 9 traps with err set
        applyStimulus(0, 1, 10'h09C, 0, 1, 32'h0, "ill_idle");
        applyStimulus(0, 1, 10'h09C, 0, 1, mk(0, 4, 0, T_ADR, 0), "ill_fet1");
        applyStimulus(0, 1, 10'h09C, 0, 1, mk(0, 0, 2, T_INC | T_IR, M_REQ), "ill_fet2");
        applyStimulus(0, 1, 10'h09C, 0, 1, 32'h0, "ill_dec");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 10'h09C, 0, 1, mk(0, 0, 0, 0, M_HLT | M_ERR), "ill_halt");
        midReset("ill_async_rst");

        // Wide instance: ADD R7 -> R5, PC select code is 8
        applyStimulus(1, 1, 10'h07D, 0, 1, 32'h0, "w_idle");
        applyStimulus(1, 1, 10'h07D, 0, 1, mk(0, 8, 0, T_ADR, 0), "w_fet1");
        applyStimulus(1, 1, 10'h07D, 0, 1, mk(0, 0, 2, T_INC | T_IR, M_REQ), "w_fet2");
        applyStimulus(1, 1, 10'h07D, 0, 1, mk(0, 7, 0, T_Y, 0), "w_dec");
        applyStimulus(1, 1, 10'h07D, 0, 1, mk(8'b0010_0000, 5, 0, T_Z, 0), "w_ex1");
        applyStimulus(1, 1, 10'h07D, 0, 1, mk(0, 8, 0, T_ADR, 0), "w_fet1_again");

        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_spm_ctrl.md
# risc_spm_ctrl

Parametrised control unit for the RISC-SPM processor family. It sequences fetch, decode and execute for a register file of configurable size and drives the datapath with one-hot register loads and bus-select codes. It adds three things the fixed 4-register controller lacks:
- a memory wait-state handshake;
- an explicit HALT opcode;
- illegal-opcode trapping.

It sits between the processing unit and the memory unit, and sources `write`.

## Interface
Parameters:
- `WORD_SIZE`, 8: instruction/data width; must be ≥ 4 + 2·`REG_ADDR_W`.
- `REG_ADDR_W`, 2: register-field width; `NUM_REGS` = 2^`REG_ADDR_W`.
- `SEL1_W`, derived: $clog2(`NUM_REGS`+1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `instruction` in `WORD_SIZE`: IR contents.
  - opcode = [`WORD_SIZE`-1 -: 4]
  - src = [2·`REG_ADDR_W`-1 : `REG_ADDR_W`]
  - dest = [`REG_ADDR_W`-1 : 0]
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `load_reg` out `NUM_REGS`: one-hot register load.
- `load_pc`, `inc_pc`, `load_ir`, `load_add_r`, `load_reg_y`, `load_reg_z` out 1 each: datapath strobes.
- `sel_bus_1` out `SEL1_W`: values 0..`NUM_REGS`-1 select R_i; `NUM_REGS` selects PC.
- `sel_bus_2` out 2: 0 = ALU, 1 = Bus_1, 2 = mem_word, 3 = reserved.
- `mem_req` out 1: memory access active.
- `write` out 1: memory write.
- `halted` out 1: controller stopped.
- `err` out 1: stop was caused by an illegal opcode.

## Operation
Opcodes: NOP 0, ADD 1, SUB 2, AND 3, NOT 4, RD 5, WR 6, BR 7, BRZ 8, HALT F. Opcodes 9–E are illegal.

States: IDLE, FET1, FET2, DEC, EX1, RD1, RD2, WR1, WR2, BR1, BR2, HALT.

State actions and transitions:
- **IDLE:** no outputs asserted → FET1.
- **FET1:** `sel_bus_1`=PC, `load_add_r` → FET2.
- **FET2 (mem):** `sel_bus_2`=mem, `load_ir`, `inc_pc` → DEC.
- **DEC, by opcode:**
  - NOP → FET1.
  - ADD/SUB/AND: `sel_bus_1`=src, `load_reg_y` → EX1.
  - NOT: `sel_bus_1`=src, `sel_bus_2`=ALU, `load_reg[dest]`, `load_reg_z` → FET1.
  - RD, WR, BR, and BRZ with `zero`=1: `sel_bus_1`=PC, `load_add_r` → RD1 / WR1 / BR1 / BR1.
  - BRZ with `zero`=0: `inc_pc` → FET1.
  - HALT → HALT.
  - illegal → HALT, with `err` set.
- **EX1:** `sel_bus_1`=dest, `sel_bus_2`=ALU, `load_reg[dest]`, `load_reg_z` → FET1.
- **RD1 / WR1 (mem):** `sel_bus_2`=mem, `load_add_r`, `inc_pc` → RD2 / WR2.
- **RD2 (mem):** `sel_bus_2`=mem, `load_reg[dest]` → FET1.
- **WR2 (mem):** `sel_bus_1`=src, `write` → FET1.
- **BR1 (mem):** `sel_bus_2`=mem, `load_add_r` → BR2.
- **BR2 (mem):** `sel_bus_2`=mem, `load_pc` → FET1.
- **HALT:** `halted`=1; `err` is held as latched. The controller stays in HALT until `rst`.

Memory-state rules (states marked "mem"):
- `mem_req`=1 for the whole state.
- While `mem_ready`=0: the state holds, selects are held, and all load/inc strobes and `write` are forced to 0.
- Strobes and the transition occur only in the cycle where `mem_ready`=1.

## Timing
- State and the `err` flag are registered. All other outputs are combinational from state, IR and `zero`.
- Reset (`rst`=0, asynchronous): state → IDLE, `err` → 0; every output is 0, including `load_reg`=0, `sel_bus_1`=0 and `sel_bus_2`=0.
- Reset asserted mid-instruction aborts the instruction immediately; no strobe fires after assertion.
- Zero-wait instruction lengths, counted from FET1: NOP 3 cycles; NOT 3; ALU ops 4; BRZ not taken 3; RD/WR/BR 5.
- Each cycle with `mem_ready`=0 in a mem state adds 1 cycle.
- `zero` is sampled only in DEC of BRZ.
- `load_reg` has at most one bit set, and is all-zero outside DEC, EX1 and RD2.

## Structure
- Shared package `risc_spm_pkg` holds the opcode constants, the state enum, and the `sel_bus_2` codes.
- The sub-module `risc_spm_ctrl_dec` is the pure combinational output decoder: state + IR + `zero` + `mem_ready` → strobes.
- `risc_spm_ctrl` holds the state register, `err` register and next-state logic, and instantiates the decoder.

## Test plan
All scenarios use `WORD_SIZE`=8, `REG_ADDR_W`=2 unless stated.

1. Release `rst` with `mem_ready`=1 and IR=8'h1B (ADD R2→R3) → the sequence IDLE, FET1, FET2, DEC with `sel_bus_1`=2 and `load_reg_y`, then EX1 with `load_reg`=4'b1000, `sel_bus_2`=0 and `load_reg_z`, then back to FET1.
2. RD (IR=8'h51) with `mem_ready` low for 3 cycles in RD2 → `mem_req` held high, no strobes during the stall, then `load_reg`=4'b0010 in exactly one cycle. Total RD length is 8 cycles.
3. BRZ (IR=8'h80) with `zero`=0 → `inc_pc` in DEC and no `load_pc`. With `zero`=1 → `load_pc` pulses once in BR2.
4. IR=8'hF0 → `halted`=1 and `err`=0, held for 100 cycles. IR=8'h9C → `halted`=1 and `err`=1. Asserting `rst` clears both asynchronously.
5. Assert `rst` during WR2 while `mem_ready`=0 → `write` and `mem_req` drop to 0 immediately (asynchronously), and the controller restarts at IDLE.
6. With `REG_ADDR_W`=3 and `WORD_SIZE`=10, ADD src=7 dest=5 → `sel_bus_1`=7 then `load_reg`=8'b0010_0000. A read of PC shows `sel_bus_1`=8.
